// File: rtl/mips_cpu_pkg.sv
// Shared types for the MIPS CPU memory arbiter: FSM states, starvation limit, and the registered memory operation.
// No logic lives here; the arbiter and its priority selector import this package.
package mips_cpu_pkg;

    localparam int STARVE_LIMIT_DEFAULT = 4;
    localparam logic [3:0] BE_ALL = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [31:0] address;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  byteenable;
    } mem_op_t;

endpackage

// File: rtl/mips_cpu_arb_prio.sv
// Priority select between fetch and data ports: data wins unless the fetch port is starved.
// Combinational, zero latency; the grant is one-hot and is all zero when nothing is requested.
module mips_cpu_arb_prio (
    input  logic       instr_req_i,
    input  logic       data_req_i,
    input  logic       starve_i,
    output logic [1:0] grant_o      // [0] = instruction, [1] = data
);

    always_comb begin
        grant_o = 2'b00;
        if (instr_req_i && starve_i) begin
            grant_o = 2'b01;
        end else if (data_req_i) begin
            grant_o = 2'b10;
        end else if (instr_req_i) begin
            grant_o = 2'b01;
        end
    end

endmodule

// File: rtl/mips_cpu_mem_arbiter.sv
// Shares one memory port between instruction fetch and data access. Each access takes one IDLE cycle and one or more BUSY cycles,
// so a zero-wait access completes in 2 cycles. mem_waitrequest stretches BUSY with all mem_* fields held stable.
module mips_cpu_mem_arbiter
    import mips_cpu_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        instr_req,
    input  logic [31:0] instr_address,
    output logic        instr_gnt,
    output logic        instr_rvalid,
    output logic [31:0] instr_rdata,

    input  logic        data_req,
    input  logic        data_we,
    input  logic [31:0] data_address,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_byteenable,
    output logic        data_gnt,
    output logic        data_rvalid,
    output logic [31:0] data_rdata,

    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_byteenable,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata
);

    localparam int CW = $clog2(STARVE_LIMIT + 2);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    arb_state_e  state_q, state_d;
    mem_op_t     op_q, op_d;
    logic        instr_gnt_q, instr_gnt_d;
    logic        data_gnt_q, data_gnt_d;
    logic        instr_rvalid_q, instr_rvalid_d;
    logic        data_rvalid_q, data_rvalid_d;
    logic [31:0] instr_rdata_q, instr_rdata_d;
    logic [31:0] data_rdata_q, data_rdata_d;
    logic [CW-1:0] starve_cnt_q, starve_cnt_d;
    logic [1:0]  grant;

    mips_cpu_arb_prio u_prio (
        .instr_req_i (instr_req),
        .data_req_i  (data_req),
        .starve_i    (starve_cnt_q == LIMIT),
        .grant_o     (grant)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            op_q           <= '0;
            instr_gnt_q    <= 1'b0;
            data_gnt_q     <= 1'b0;
            instr_rvalid_q <= 1'b0;
            data_rvalid_q  <= 1'b0;
            instr_rdata_q  <= '0;
            data_rdata_q   <= '0;
            starve_cnt_q   <= '0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            instr_gnt_q    <= instr_gnt_d;
            data_gnt_q     <= data_gnt_d;
            instr_rvalid_q <= instr_rvalid_d;
            data_rvalid_q  <= data_rvalid_d;
            instr_rdata_q  <= instr_rdata_d;
            data_rdata_q   <= data_rdata_d;
            starve_cnt_q   <= starve_cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        instr_gnt_d    = 1'b0;
        data_gnt_d     = 1'b0;
        instr_rvalid_d = 1'b0;
        data_rvalid_d  = 1'b0;
        instr_rdata_d  = instr_rdata_q;
        data_rdata_d   = data_rdata_q;
        starve_cnt_d   = starve_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (grant[1]) begin
                    state_d         = ST_BUSY_D;
                    data_gnt_d      = 1'b1;
                    op_d.address    = data_address;
                    op_d.we         = data_we;
                    op_d.wdata      = data_we ? data_wdata : 32'h0;
                    op_d.byteenable = data_we ? data_byteenable : BE_ALL;
                    // Only data grants that bypass a waiting fetch count toward starvation.
                    if (instr_req && (starve_cnt_q != LIMIT)) begin
                        starve_cnt_d = starve_cnt_q + CW'(1);
                    end
                end else if (grant[0]) begin
                    state_d         = ST_BUSY_I;
                    instr_gnt_d     = 1'b1;
                    op_d.address    = instr_address;
                    op_d.we         = 1'b0;
                    op_d.wdata      = 32'h0;
                    op_d.byteenable = BE_ALL;
                    starve_cnt_d    = '0;
                end
            end
            ST_BUSY_I: begin
                if (!mem_waitrequest) begin
                    state_d        = ST_IDLE;
                    instr_rvalid_d = 1'b1;
                    instr_rdata_d  = mem_readdata;
                end
            end
            ST_BUSY_D: begin
                if (!mem_waitrequest) begin
                    state_d       = ST_IDLE;
                    data_rvalid_d = 1'b1;
                    data_rdata_d  = op_q.we ? 32'h0 : mem_readdata;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes decode from state so they drop the moment the FSM is in IDLE or reset.
    assign mem_read       = (state_q != ST_IDLE) && !op_q.we;
    assign mem_write      = (state_q != ST_IDLE) && op_q.we;
    assign mem_address    = op_q.address & 32'hFFFF_FFFC;
    assign mem_writedata  = op_q.wdata;
    assign mem_byteenable = op_q.byteenable;

    assign instr_gnt    = instr_gnt_q;
    assign data_gnt     = data_gnt_q;
    assign instr_rvalid = instr_rvalid_q;
    assign data_rvalid  = data_rvalid_q;
    assign instr_rdata  = instr_rdata_q;
    assign data_rdata   = data_rdata_q;

endmodule

// File: doc/mips_cpu_mem_arbiter.md
MIPS_CPU_MEM_ARBITER -- requirements
Module: mips_cpu_mem_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset; parameter STARVE_LIMIT, default 4, is the maximum number of consecutive data grants while an instruction request waits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 instr_req  input  1  fetch request, held until instr_gnt.
REQ-005 instr_address  input  32  fetch byte address.
REQ-006 instr_gnt  output  1  one-cycle pulse: fetch accepted, inputs may change.
REQ-007 instr_rvalid  output  1  one-cycle pulse: instr_rdata valid.
REQ-008 instr_rdata  output  32  fetched word.
REQ-009 data_req  input  1  data request, held until data_gnt.
REQ-010 data_we  input  1  1 = write, 0 = read.
REQ-011 data_address  input  32  data byte address.
REQ-012 data_wdata  input  32  write data.
REQ-013 data_byteenable  input  4  write byte lanes.
REQ-014 data_gnt  output  1  one-cycle pulse: data request accepted.
REQ-015 data_rvalid  output  1  one-cycle pulse: data access complete (read or write).
REQ-016 data_rdata  output  32  read word (0 on write completion).
REQ-017 mem_address  output  32  memory word address, bits[1:0] forced to 0.
REQ-018 mem_read / mem_write  output  1 each  memory strobes, never both high.
REQ-019 mem_writedata  output  32;  mem_byteenable  output  4 (4'hF on reads).
REQ-020 mem_waitrequest  input  1  memory stall; mem_readdata  input  32.

Function
REQ-021 The FSM SHALL have states IDLE, BUSY_I and BUSY_D.
REQ-022 In IDLE with any request pending, the next edge SHALL enter BUSY_I or BUSY_D, register the winner's mem_* fields and pulse the winner's gnt in the first BUSY cycle.
REQ-023 Priority: data over instruction, except that instruction SHALL win when starve_cnt == STARVE_LIMIT and instr_req = 1.
REQ-024 starve_cnt SHALL increment on each data grant made while instr_req = 1, clear on any instruction grant, and saturate at STARVE_LIMIT.
REQ-025 In BUSY, mem_* SHALL stay stable while mem_waitrequest = 1.
REQ-026 A BUSY cycle with mem_waitrequest = 0 SHALL complete the transaction: capture mem_readdata for reads, return to IDLE, and pulse the owner's rvalid in the following cycle.
REQ-027 mem_read and mem_write SHALL be 0 in IDLE.
REQ-028 Throughput SHALL be one transaction per 2 cycles at zero wait states; latency from req in IDLE to rvalid SHALL be 2 cycles plus the number of wait cycles.
REQ-029 Simultaneous instr_req and data_req SHALL resolve per REQ-023; the loser stays pending and is served next.
REQ-030 Requests deasserted before gnt SHALL be dropped silently.
REQ-031 rdata outputs SHALL hold their last value until the next rvalid of the same port.

Reset
REQ-032 With reset_n = 0, asynchronously: state = IDLE, starve_cnt = 0, all outputs 0, mem_byteenable = 0; any in-flight transaction SHALL be abandoned with no rvalid issued.
REQ-033 After reset release, the first arbitration SHALL occur at the first rising edge with reset_n = 1.

Structure
REQ-034 The state enum, STARVE_LIMIT default and the mem-op struct (address, we, wdata, byteenable) SHALL live in package mips_cpu_pkg.
REQ-035 Priority selection SHALL be a sub-module mips_cpu_arb_prio (inputs: both reqs, starve flag; output: one-hot grant); everything else stays flat.

Verification
REQ-036 Instruction-only read at 0xBFC00000, waitrequest = 0, memory word 0x3C08DEAD -> instr_gnt in cycle 1, mem_address = 0xBFC00000, instr_rvalid in cycle 2 with instr_rdata = 0x3C08DEAD.
REQ-037 Simultaneous instr_req and data write (0x00001003, 0xCAFEF00D, byteenable 4'b0011) -> data granted first with mem_address 0x00001000 and mem_write = 1; instruction granted in the next IDLE.
REQ-038 data_req held continuously with instr_req pending, STARVE_LIMIT = 4 -> 4 data grants, then 1 instruction grant, then starve_cnt = 0.
REQ-039 Data read with 3 wait cycles -> mem_* stable for 4 cycles, data_rvalid exactly once, 1 cycle after waitrequest falls.
REQ-040 reset_n asserted mid-BUSY_D -> all outputs 0 immediately, no data_rvalid; after release, a fresh instruction request is served normally.
REQ-041 A checker over every scenario SHALL assert: mem_read and mem_write are never both 1, and every gnt is followed by exactly one rvalid unless a reset occurs between them.
